// File: rtl/sdlib_pkg.sv
// rtl/sdlib_pkg.sv - shared sdlib constants: scoreboard request-type encoding
package sdlib_pkg;

  localparam logic REQ_READ  = 1'b0;
  localparam logic REQ_WRITE = 1'b1;

endpackage

// File: rtl/sd_sbreq_prienc.sv
// rtl/sd_sbreq_prienc.sv - lowest-index-set priority encoder for free txid selection
module sd_sbreq_prienc #(
  parameter int n  = 4,
  parameter int iw = 2
) (
  input  logic [n-1:0]  req,
  output logic [iw-1:0] index,
  output logic          any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    index = '0;
    for (int i = n - 1; i >= 0; i--) begin
      if (req[i]) index = iw'(i);
    end
  end

  assign any = |req;

endmodule

// File: rtl/sd_scoreboard_req.sv
// rtl/sd_scoreboard_req.sv - scoreboard requester: txid allocation, tag table, one-entry result register
// Optional unexpected-response checking: define SDLIB_SBREQ_ERRCHK_EN.
module sd_scoreboard_req
  import sdlib_pkg::*;
#(
  parameter int width   = 8,
  parameter int items   = 64,
  parameter int txid_sz = 2,
  parameter int asz     = $clog2(items)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               c_srdy,
  output logic               c_drdy,
  input  logic               c_req_type,
  input  logic [width-1:0]   c_mask,
  input  logic [width-1:0]   c_data,
  input  logic [asz-1:0]     c_itemid,
  output logic               ip_srdy,
  input  logic               ip_drdy,
  output logic               ip_req_type,
  output logic [txid_sz-1:0] ip_txid,
  output logic [width-1:0]   ip_mask,
  output logic [width-1:0]   ip_data,
  output logic [asz-1:0]     ip_itemid,
  input  logic               ic_srdy,
  output logic               ic_drdy,
  input  logic [txid_sz-1:0] ic_txid,
  input  logic [width-1:0]   ic_data,
  output logic               p_srdy,
  input  logic               p_drdy,
  output logic [asz-1:0]     p_itemid,
  output logic [width-1:0]   p_data,
  output logic [txid_sz:0]   outstanding,
  output logic               err_unexp
);

  localparam int ntx = 2 ** txid_sz;
  localparam logic [txid_sz:0] out_max = (txid_sz + 1)'(ntx);

  logic [ntx-1:0]     free;
  logic [asz-1:0]     tag [ntx];
  logic [txid_sz-1:0] free_idx;
  logic               any_free;
  logic               is_read, rd_xfer, ic_xfer, rsp_ok, rsp_err;

  sd_sbreq_prienc #(.n(ntx), .iw(txid_sz)) u_prienc (
    .req   (free),
    .index (free_idx),
    .any   (any_free)
  );

  assign is_read     = (c_req_type == REQ_READ);
  assign ip_srdy     = c_srdy & (!is_read | any_free);
  assign c_drdy      = ip_drdy & (!is_read | any_free);
  assign ip_req_type = c_req_type;
  assign ip_mask     = c_mask;
  assign ip_data     = c_data;
  assign ip_itemid   = c_itemid;
  assign ip_txid     = is_read ? free_idx : '0;
  assign rd_xfer     = ip_srdy & ip_drdy & is_read;

  assign ic_drdy = !p_srdy | p_drdy;
  assign ic_xfer = ic_srdy & ic_drdy;

`ifdef SDLIB_SBREQ_ERRCHK_EN
  assign rsp_err = ic_xfer & free[ic_txid];
`else
  assign rsp_err = 1'b0;
`endif
  assign rsp_ok = ic_xfer & !rsp_err;

  // Allocation is written last so it wins if both ever target the same id.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      free <= '1;
    end else begin
      if (rsp_ok)  free[ic_txid]  <= 1'b1;
      if (rd_xfer) free[free_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_xfer) tag[free_idx] <= c_itemid;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      case ({rd_xfer && outstanding != out_max, rsp_ok && outstanding != '0})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_srdy    <= 1'b0;
      p_data    <= '0;
      p_itemid  <= '0;
      err_unexp <= 1'b0;
    end else begin
      err_unexp <= rsp_err;
      if (rsp_ok) begin
        p_srdy   <= 1'b1;
        p_data   <= ic_data;
        p_itemid <= tag[ic_txid];
      end else if (p_drdy) begin
        p_srdy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sd_scoreboard_req.sv
// tb/tb_sd_scoreboard_req.sv - self-checking bench for sd_scoreboard_req with a result scoreboard
module tb_sd_scoreboard_req;

  localparam int W = 8;
  localparam int A = 6;
  localparam int T = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         c_srdy, c_drdy, c_req_type;
  logic [W-1:0] c_mask, c_data;
  logic [A-1:0] c_itemid;
  logic         ip_srdy, ip_drdy, ip_req_type;
  logic [T-1:0] ip_txid;
  logic [W-1:0] ip_mask, ip_data;
  logic [A-1:0] ip_itemid;
  logic         ic_srdy, ic_drdy;
  logic [T-1:0] ic_txid;
  logic [W-1:0] ic_data;
  logic         p_srdy, p_drdy;
  logic [A-1:0] p_itemid;
  logic [W-1:0] p_data;
  logic [T:0]   outstanding;
  logic         err_unexp;

  int errors = 0;
  int checks = 0;

  logic [A+W-1:0] exp_q [$];
  logic [3:0]     m_free;
  logic [A-1:0]   m_tag [4];

  sd_scoreboard_req #(.width(W), .items(64), .txid_sz(T)) dut (
    .clk(clk), .reset(reset),
    .c_srdy(c_srdy), .c_drdy(c_drdy), .c_req_type(c_req_type),
    .c_mask(c_mask), .c_data(c_data), .c_itemid(c_itemid),
    .ip_srdy(ip_srdy), .ip_drdy(ip_drdy), .ip_req_type(ip_req_type),
    .ip_txid(ip_txid), .ip_mask(ip_mask), .ip_data(ip_data), .ip_itemid(ip_itemid),
    .ic_srdy(ic_srdy), .ic_drdy(ic_drdy), .ic_txid(ic_txid), .ic_data(ic_data),
    .p_srdy(p_srdy), .p_drdy(p_drdy), .p_itemid(p_itemid), .p_data(p_data),
    .outstanding(outstanding), .err_unexp(err_unexp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int lowest_free();
    for (int i = 0; i < 4; i++) if (m_free[i]) return i;
    return -1;
  endfunction

  // Drive one command for one cycle; the model decides txid and acceptance.
  task automatic cmd(input logic typ, input logic [A-1:0] item, input logic [W-1:0] d, input logic [W-1:0] m);
    int  id;
    logic acc;
    @(negedge clk);
    c_srdy = 1'b1; c_req_type = typ; c_itemid = item; c_data = d; c_mask = m;
    id  = (typ == 1'b0) ? lowest_free() : 0;
    acc = (typ == 1'b1) || (id >= 0);
    #1;
    check("c_drdy", 32'(c_drdy), 32'(acc));
    check("ip_srdy", 32'(ip_srdy), 32'(acc));
    check("ip_itemid", 32'(ip_itemid), 32'(item));
    check("ip_data", 32'(ip_data), 32'(d));
    check("ip_mask", 32'(ip_mask), 32'(m));
    check("ip_req_type", 32'(ip_req_type), 32'(typ));
    if (acc) check("ip_txid", 32'(ip_txid), 32'(id));
    if (acc && typ == 1'b0) begin
      m_free[id] = 1'b0;
      m_tag[id]  = item;
    end
    @(posedge clk); #1;
    c_srdy = 1'b0;
  endtask

  task automatic rsp(input int id, input logic [W-1:0] d);
    @(negedge clk);
    ic_srdy = 1'b1; ic_txid = T'(id); ic_data = d;
    #1;
    check("ic_drdy", 32'(ic_drdy), 32'(1));
    exp_q.push_back({m_tag[id], d});
    m_free[id] = 1'b1;
    @(posedge clk); #1;
    ic_srdy = 1'b0;
  endtask

  // Scoreboard pop: a result is consumed whenever p_srdy and p_drdy meet.
  initial begin
    forever begin
      @(negedge clk); #2;
      if (reset === 1'b0 && p_srdy === 1'b1 && p_drdy === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'(p_itemid), 32'hFFFF_FFFF);
        end else begin
          logic [A+W-1:0] e;
          e = exp_q.pop_front();
          check("res_itemid", 32'(p_itemid), 32'(e[A+W-1:W]));
          check("res_data", 32'(p_data), 32'(e[W-1:0]));
        end
      end
    end
  end

  initial begin
    logic [W-1:0] held;
    reset = 1'b1; c_srdy = 0; c_req_type = 0; c_mask = 0; c_data = 0; c_itemid = 0;
    ip_drdy = 1; ic_srdy = 0; ic_txid = 0; ic_data = 0; p_drdy = 1;
    m_free = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outstanding", 32'(outstanding), 0);
    check("rst_p_srdy", 32'(p_srdy), 0);
    check("rst_p_data", 32'(p_data), 0);
    check("rst_p_itemid", 32'(p_itemid), 0);
    check("rst_err", 32'(err_unexp), 0);
    check("rst_ic_drdy", 32'(ic_drdy), 1);
    @(negedge clk); reset = 1'b0;

    // Write passes straight through with txid 0.
    cmd(1'b1, 6'd5, 8'hA5, 8'hFF);
    check("wr_outstanding", 32'(outstanding), 0);

    // Single read round trip.
    cmd(1'b0, 6'd3, 8'h00, 8'h00);
    check("rd_outstanding", 32'(outstanding), 1);
    rsp(0, 8'h3C);
    check("rt_p_srdy", 32'(p_srdy), 1);
    check("rt_p_itemid", 32'(p_itemid), 3);
    check("rt_p_data", 32'(p_data), 32'h3C);
    check("rt_outstanding", 32'(outstanding), 0);

    // Fill all ids, then a stalled read and an accepted write.
    for (int i = 1; i <= 4; i++) cmd(1'b0, A'(i), 8'h00, 8'h00);
    check("full_outstanding", 32'(outstanding), 4);
    cmd(1'b0, 6'd9, 8'h00, 8'h00);
    cmd(1'b1, 6'd12, 8'h5A, 8'h0F);
    check("full_outstanding2", 32'(outstanding), 4);

    // Out-of-order responses, then the lowest freed id is reused.
    rsp(2, 8'h11);
    rsp(0, 8'h22);
    check("ooo_outstanding", 32'(outstanding), 2);
    cmd(1'b0, 6'd7, 8'h00, 8'h00);
    check("realloc_outstanding", 32'(outstanding), 3);

    // Backpressure: result held while p_drdy is low, then one per cycle.
    @(negedge clk); p_drdy = 1'b0;
    rsp(1, 8'h33);
    held = p_data;
    @(negedge clk);
    ic_srdy = 1'b1; ic_txid = 2'd3; ic_data = 8'h44;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_ic_drdy", 32'(ic_drdy), 0);
      check("bp_p_srdy", 32'(p_srdy), 1);
      check("bp_p_data", 32'(p_data), 32'(held));
      @(negedge clk);
    end
    p_drdy = 1'b1;
    #1;
    check("rel_ic_drdy", 32'(ic_drdy), 1);
    exp_q.push_back({m_tag[3], 8'h44}); m_free[3] = 1'b1;
    @(negedge clk);
    ic_txid = 2'd0; ic_data = 8'h55;
    #1;
    check("b2b_ic_drdy", 32'(ic_drdy), 1);
    check("b2b_p_srdy", 32'(p_srdy), 1);
    exp_q.push_back({m_tag[0], 8'h55}); m_free[0] = 1'b1;
    @(posedge clk); #1;
    ic_srdy = 1'b0;
    check("b2b_p_data", 32'(p_data), 32'h55);
    check("drain_outstanding", 32'(outstanding), 0);

    // Allocation and free in the same cycle leave the count unchanged.
    cmd(1'b0, 6'd9, 8'h00, 8'h00);
    @(negedge clk);
    c_srdy = 1'b1; c_req_type = 1'b0; c_itemid = 6'd10;
    ic_srdy = 1'b1; ic_txid = 2'd0; ic_data = 8'h66;
    #1;
    check("same_ip_txid", 32'(ip_txid), 1);
    exp_q.push_back({m_tag[0], 8'h66}); m_free[0] = 1'b1;
    m_free[1] = 1'b0; m_tag[1] = 6'd10;
    @(posedge clk); #1;
    c_srdy = 1'b0; ic_srdy = 1'b0;
    check("same_outstanding", 32'(outstanding), 1);
    rsp(1, 8'h77);
    check("same_drain", 32'(outstanding), 0);

    // Reset in the middle of a read burst.
    cmd(1'b0, 6'd20, 8'h00, 8'h00);
    cmd(1'b0, 6'd21, 8'h00, 8'h00);
    @(negedge clk); reset = 1'b1;
    #1;
    check("mid_rst_outstanding", 32'(outstanding), 0);
    check("mid_rst_p_srdy", 32'(p_srdy), 0);
    m_free = 4'hF;
    exp_q.delete();
    @(negedge clk); reset = 1'b0;
    cmd(1'b0, 6'd22, 8'h00, 8'h00);
    check("post_rst_outstanding", 32'(outstanding), 1);
    rsp(0, 8'h88);
    @(negedge clk);

`ifdef SDLIB_SBREQ_ERRCHK_EN
    // Response to an id that is free is flagged and dropped.
    @(negedge clk);
    ic_srdy = 1'b1; ic_txid = 2'd1; ic_data = 8'h99;
    @(posedge clk); #1;
    ic_srdy = 1'b0;
    check("err_pulse", 32'(err_unexp), 1);
    check("err_p_srdy", 32'(p_srdy), 0);
    check("err_outstanding", 32'(outstanding), 0);
    @(posedge clk); #1;
    check("err_pulse_end", 32'(err_unexp), 0);
`else
    check("err_tied", 32'(err_unexp), 0);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
